cov_matrix_builder: RTL and testbench

- Producer-side front end for linear_solver.
- Accepts a stream of 4-asset return samples (signed Q3.13), accumulates first and second moments over a window of 2^LOG2N samples, then computes the 4x4 covariance matrix.
- Presents the matrix on cov with cov_valid held high until the solver signals completion on its ready output. It then clears and starts the next window.

---
 rtl/cov_matrix_builder.sv | 168 ++++++++++++++++
 tb/tb_cov_matrix_builder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cov_matrix_builder.sv
// Streaming 4x4 covariance builder: accumulates moments over 2^LOG2N
// samples, computes one matrix pair per cycle, then presents to the solver.
module cov_matrix_builder #(
  parameter int LOG2N = 4,
  parameter int FRAC  = 13
) (
  input  logic                   clk_100mhz,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [0:3][15:0]       sample,
  output logic                   sample_ready,
  input  logic                   solver_ready,
  output logic [0:3][0:3][15:0]  cov,
  output logic                   cov_valid,
  output logic                   cov_sat,
  output logic [LOG2N:0]         sample_count
);

  localparam int SW = 16 + LOG2N;
  localparam int PW = 32 + LOG2N;
  localparam int CW = 34;
  localparam logic [LOG2N:0] NS = {1'b1, {LOG2N{1'b0}}};

  // Pair k is (PI[k], PJ[k]); P accumulators use the same ordering.
  localparam logic [1:0] PI [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
                                     2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  localparam logic [1:0] PJ [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1,
                                     2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  typedef enum logic [1:0] {ACCUM, COMPUTE, PRESENT} state_e;

  state_e                  state_q, state_d;
  logic [LOG2N:0]          cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              wr_idx_q, wr_idx_d;
  logic                    wr_en_q, wr_en_d;
  logic signed [CW-1:0]    c_q, c_d;
  logic [0:3][0:3][15:0]   cov_q, cov_d;
  logic                    cov_sat_q, cov_sat_d;
  logic                    cov_valid_q, cov_valid_d;
  logic                    sr_prev_q;
  logic signed [SW-1:0]    s_q [4];
  logic signed [SW-1:0]    s_d [4];
  logic signed [PW-1:0]    p_q [10];
  logic signed [PW-1:0]    p_d [10];

  logic signed [15:0]      mi, mj;
  logic signed [31:0]      e, mm;
  logic signed [CW-1:0]    r;
  logic [15:0]             res;
  logic                    sat;
  logic                    done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    s_d         = s_q;
    p_d         = p_q;
    cov_d       = cov_q;
    cov_sat_d   = cov_sat_q;
    cov_valid_d = cov_valid_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = idx_q;

    mi  = 16'(s_q[PI[idx_q]] >>> LOG2N);
    mj  = 16'(s_q[PJ[idx_q]] >>> LOG2N);
    e   = 32'(p_q[idx_q] >>> LOG2N);
    mm  = mi * mj;
    c_d = CW'(e) - CW'(mm);

    // Writeback stage: rescale the registered difference and saturate.
    r   = c_q >>> FRAC;
    res = r[15:0];
    sat = 1'b0;
    if (r > CW'(32767)) begin
      res = 16'h7fff;
      sat = 1'b1;
    end else if (r < CW'(-32768)) begin
      res = 16'h8000;
      sat = 1'b1;
    end

    done = (state_q == PRESENT) && cov_valid_q &&
           solver_ready && !sr_prev_q;

    if (wr_en_q) begin
      cov_d[PI[wr_idx_q]][PJ[wr_idx_q]] = res;
      cov_d[PJ[wr_idx_q]][PI[wr_idx_q]] = res;
      if (sat) cov_sat_d = 1'b1;
    end

    unique case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          for (int i = 0; i < 4; i++)
            s_d[i] = s_q[i] + SW'($signed(sample[i]));
          for (int k = 0; k < 10; k++)
            p_d[k] = p_q[k] + PW'(32'($signed(sample[PI[k]])) *
                                  32'($signed(sample[PJ[k]])));
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == NS - 1'b1) begin
            state_d   = COMPUTE;
            idx_d     = '0;
            cov_sat_d = 1'b0;
          end
        end
      end
      COMPUTE: begin
        wr_en_d  = 1'b1;
        wr_idx_d = idx_q;
        idx_d    = idx_q + 1'b1;
        if (idx_q == 4'd9) begin
          state_d = PRESENT;
          idx_d   = '0;
        end
      end
      PRESENT: begin
        cov_valid_d = 1'b1;
        if (done) begin
          cov_valid_d = 1'b0;
          state_d     = ACCUM;
          cnt_d       = '0;
          for (int i = 0; i < 4; i++) s_d[i] = '0;
          for (int k = 0; k < 10; k++) p_d[k] = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      wr_idx_q    <= '0;
      wr_en_q     <= 1'b0;
      c_q         <= '0;
      cov_q       <= '0;
      cov_sat_q   <= 1'b0;
      cov_valid_q <= 1'b0;
      sr_prev_q   <= 1'b0;
      for (int i = 0; i < 4; i++) s_q[i] <= '0;
      for (int k = 0; k < 10; k++) p_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_idx_q    <= wr_idx_d;
      wr_en_q     <= wr_en_d;
      c_q         <= c_d;
      cov_q       <= cov_d;
      cov_sat_q   <= cov_sat_d;
      cov_valid_q <= cov_valid_d;
      sr_prev_q   <= solver_ready;
      for (int i = 0; i < 4; i++) s_q[i] <= s_d[i];
      for (int k = 0; k < 10; k++) p_q[k] <= p_d[k];
    end
  end

  assign sample_ready = (state_q == ACCUM);
  assign cov          = cov_q;
  assign cov_valid    = cov_valid_q;
  assign cov_sat      = cov_sat_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_cov_matrix_builder.sv
// Directed bench for cov_matrix_builder with a 4-sample window.
module tb_cov_matrix_builder;

  localparam int LOG2N = 2;

  logic                  clk;
  logic                  reset;
  logic                  sample_valid;
  logic [0:3][15:0]      sample;
  logic                  sample_ready;
  logic                  solver_ready;
  logic [0:3][0:3][15:0] cov;
  logic                  cov_valid;
  logic                  cov_sat;
  logic [LOG2N:0]        sample_count;

  cov_matrix_builder #(.LOG2N(LOG2N), .FRAC(13)) dut (
    .clk_100mhz   (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ready (sample_ready),
    .solver_ready (solver_ready),
    .cov          (cov),
    .cov_valid    (cov_valid),
    .cov_sat      (cov_sat),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int lat;
  logic [0:3][15:0]      frm [4];
  logic [0:3][0:3][15:0] exp_cov;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      sample       = frm[b];
      sample_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (cov_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic complete();
    @(negedge clk);
    solver_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("done_valid", 256'(cov_valid), 256'(1'b0));
    chk("done_ready", 256'(sample_ready), 256'(1'b1));
    @(negedge clk);
    solver_ready = 1'b0;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    solver_ready = 1'b0;
    #12;
    chk("rst_cov", 256'(cov), 256'(0));
    chk("rst_valid", 256'(cov_valid), 256'(1'b0));
    chk("rst_sat", 256'(cov_sat), 256'(1'b0));
    chk("rst_ready", 256'(sample_ready), 256'(1'b1));
    chk("rst_count", 256'(sample_count), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: constant returns, zero covariance
    for (int b = 0; b < 4; b++) frm[b] = {4{16'h2000}};
    drive_frame();
    wait_valid(lat);
    chk("f1_latency", 256'(lat), 256'(11));
    chk("f1_cov", 256'(cov), 256'(0));
    chk("f1_sat", 256'(cov_sat), 256'(1'b0));
    chk("f1_sready", 256'(sample_ready), 256'(1'b0));
    complete();

    // Frame 2: anti-correlated assets 0 and 1, long hold
    frm[0] = {16'h2000, 16'hF000, 16'h0000, 16'h0000};
    frm[1] = {16'hE000, 16'h1000, 16'h0000, 16'h0000};
    frm[2] = {16'h2000, 16'hF000, 16'h0000, 16'h0000};
    frm[3] = {16'hE000, 16'h1000, 16'h0000, 16'h0000};
    exp_cov       = '0;
    exp_cov[0][0] = 16'h2000;
    exp_cov[0][1] = 16'hF000;
    exp_cov[1][0] = 16'hF000;
    exp_cov[1][1] = 16'h0800;
    drive_frame();
    wait_valid(lat);
    chk("f2_latency", 256'(lat), 256'(11));
    chk("f2_cov", 256'(cov), 256'(exp_cov));
    chk("f2_sat", 256'(cov_sat), 256'(1'b0));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      sample       = {4{16'h1234}};
      sample_valid = c[0];
      @(posedge clk);
      #1;
      chk("hold_valid", 256'(cov_valid), 256'(1'b1));
      chk("hold_cov", 256'(cov), 256'(exp_cov));
      chk("hold_count", 256'(sample_count), 256'(4));
    end
    // Completion edge with a sample offered: sample must be dropped
    @(negedge clk);
    solver_ready = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("f2_done_valid", 256'(cov_valid), 256'(1'b0));
    chk("f2_done_ready", 256'(sample_ready), 256'(1'b1));
    chk("f2_done_count", 256'(sample_count), 256'(0));
    chk("f2_cov_hold", 256'(cov), 256'(exp_cov));
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    chk("f2_drop_count", 256'(sample_count), 256'(0));

    // Frame 3: saturation, solver_ready already high on entry
    frm[0] = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    frm[1] = {16'h8000, 16'h0000, 16'h0000, 16'h0000};
    frm[2] = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    frm[3] = {16'h8000, 16'h0000, 16'h0000, 16'h0000};
    exp_cov       = '0;
    exp_cov[0][0] = 16'h7FFF;
    drive_frame();
    wait_valid(lat);
    chk("f3_latency", 256'(lat), 256'(11));
    chk("f3_cov", 256'(cov), 256'(exp_cov));
    chk("f3_sat", 256'(cov_sat), 256'(1'b1));
    repeat (5) @(posedge clk);
    #1;
    chk("f3_level_hold", 256'(cov_valid), 256'(1'b1));
    @(negedge clk);
    solver_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("f3_fall_hold", 256'(cov_valid), 256'(1'b1));
    complete();
    chk("f3_sat_hold", 256'(cov_sat), 256'(1'b1));

    // Reset during the third COMPUTE cycle, then a clean frame
    frm[0] = {16'h2000, 16'hF000, 16'h0000, 16'h0000};
    frm[1] = {16'hE000, 16'h1000, 16'h0000, 16'h0000};
    frm[2] = {16'h2000, 16'hF000, 16'h0000, 16'h0000};
    frm[3] = {16'hE000, 16'h1000, 16'h0000, 16'h0000};
    drive_frame();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cov", 256'(cov), 256'(0));
    chk("mid_rst_valid", 256'(cov_valid), 256'(1'b0));
    chk("mid_rst_count", 256'(sample_count), 256'(0));
    chk("mid_rst_ready", 256'(sample_ready), 256'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    exp_cov       = '0;
    exp_cov[0][0] = 16'h2000;
    exp_cov[0][1] = 16'hF000;
    exp_cov[1][0] = 16'hF000;
    exp_cov[1][1] = 16'h0800;
    drive_frame();
    wait_valid(lat);
    chk("f4_latency", 256'(lat), 256'(11));
    chk("f4_cov", 256'(cov), 256'(exp_cov));
    chk("f4_sat", 256'(cov_sat), 256'(1'b0));
    complete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
